rvz_decode_stage: RTL and testbench

// Parametrised RV32I/RV64I decode stage with a valid/ready handshake on both sides.

---
 rtl/rvz_decode_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_rvz_decode_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rvz_decode_stage.sv
// RV32I/RV64I decode stage: register file with write bypass, immediate generation,
// execute control, load-use interlock and flush, valid/ready on both sides.
module rvz_decode_stage #(
  parameter int XLEN       = 64,
  parameter int PC_W       = 32,
  parameter int NREGS      = 32,
  parameter int LU_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_data,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flush,
  input  logic            reg_wenable,
  input  logic [4:0]      reg_waddr,
  input  logic [XLEN-1:0] reg_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immediate,
  output logic [XLEN-1:0] reg1_out,
  output logic [XLEN-1:0] reg2_out,
  output logic [4:0]      reg_dest,
  output logic [PC_W-1:0] pc_out,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            writeback_enable,
  output logic [1:0]      writeback_source,
  output logic [1:0]      mem_access,
  output logic            jump,
  output logic            branch,
  output logic            ALU_A_mux,
  output logic            ALU_B_mux,
  output logic            word_op,
  output logic            illegal
);
  localparam int IDX_W = $clog2(NREGS);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_OPIMMW = 7'h1B;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OPW    = 7'h3B;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic            wb;
    logic [1:0]      src;
    logic [1:0]      mem;
    logic            jump;
    logic            branch;
    logic            a_sel;
    logic            b_sel;
    logic            word;
    logic            illegal;
  } ctrl_t;

  logic [XLEN-1:0] regs [NREGS];
  logic [1:0]      bub_cnt;
  ctrl_t           dec;
  logic [6:0]      opc;
  logic [4:0]      rd, rs1, rs2;
  logic [31:0]     imm32;
  logic [63:0]     imm64;
  logic            use_rs1, use_rs2, unknown, bad_reg;
  logic            haz_rs1, haz_rs2, hazard, stall, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opc = inst_data[6:0];
  assign rd  = inst_data[11:7];
  assign rs1 = inst_data[19:15];
  assign rs2 = inst_data[24:20];

  // Out-of-range indices read as zero so illegal encodings never index past the array.
  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] a);
    if (a == 5'd0 || int'(a) >= NREGS) return '0;
    if (reg_wenable && reg_waddr == a) return reg_wdata;
    return regs[a[IDX_W-1:0]];
  endfunction

  always_comb begin
    rs1_val = rd_reg(rs1);
    rs2_val = rd_reg(rs2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_wenable && reg_waddr != 5'd0 && int'(reg_waddr) < NREGS) begin
      regs[reg_waddr[IDX_W-1:0]] <= reg_wdata;
    end
  end

  always_comb begin
    dec     = '0;
    imm32   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unknown = 1'b0;
    unique case (opc)
      OPC_LOAD: begin
        imm32 = {{20{inst_data[31]}}, inst_data[31:20]};
        dec.wb = 1'b1; dec.src = 2'b01; dec.mem = 2'b01; dec.b_sel = 1'b1; use_rs1 = 1'b1;
      end
      OPC_OPIMM: begin
        imm32 = {{20{inst_data[31]}}, inst_data[31:20]};
        dec.wb = 1'b1; dec.b_sel = 1'b1; use_rs1 = 1'b1;
      end
      OPC_AUIPC: begin
        imm32 = {inst_data[31:12], 12'b0};
        dec.wb = 1'b1; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
      end
      OPC_STORE: begin
        imm32 = {{20{inst_data[31]}}, inst_data[31:25], inst_data[11:7]};
        dec.mem = 2'b10; dec.b_sel = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OP: begin
        dec.wb = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        imm32 = {inst_data[31:12], 12'b0};
        dec.wb = 1'b1; dec.src = 2'b10;
      end
      OPC_BRANCH: begin
        imm32 = {{19{inst_data[31]}}, inst_data[31], inst_data[7], inst_data[30:25],
                 inst_data[11:8], 1'b0};
        dec.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_JALR: begin
        imm32 = {{20{inst_data[31]}}, inst_data[31:20]};
        dec.jump = 1'b1; dec.wb = 1'b1; dec.src = 2'b11; dec.b_sel = 1'b1; use_rs1 = 1'b1;
      end
      OPC_JAL: begin
        imm32 = {{11{inst_data[31]}}, inst_data[31], inst_data[19:12], inst_data[20],
                 inst_data[30:21], 1'b0};
        dec.jump = 1'b1; dec.wb = 1'b1; dec.src = 2'b11; dec.a_sel = 1'b1; dec.b_sel = 1'b1;
      end
      OPC_OPIMMW: begin
        if (XLEN == 64) begin
          imm32 = {{20{inst_data[31]}}, inst_data[31:20]};
          dec.wb = 1'b1; dec.b_sel = 1'b1; dec.word = 1'b1; use_rs1 = 1'b1;
        end else unknown = 1'b1;
      end
      OPC_OPW: begin
        if (XLEN == 64) begin
          dec.wb = 1'b1; dec.word = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        end else unknown = 1'b1;
      end
      default: unknown = 1'b1;
    endcase
    imm64   = {{32{imm32[31]}}, imm32};
    dec.imm = imm64[XLEN-1:0];
    // Only fields the format actually uses as register indices are range-checked.
    bad_reg = (dec.wb && int'(rd) >= NREGS) || (use_rs1 && int'(rs1) >= NREGS) ||
              (use_rs2 && int'(rs2) >= NREGS);
    if (unknown || bad_reg) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
    if (rd == 5'd0) dec.wb = 1'b0;
  end

  // Interlock operand usage is opcode-based, independent of legality.
  always_comb begin
    haz_rs1 = (opc != OPC_LUI) && (opc != OPC_AUIPC) && (opc != OPC_JAL) && (rs1 == reg_dest);
    haz_rs2 = ((opc == OPC_OP) || (opc == OPC_OPW) || (opc == OPC_STORE) || (opc == OPC_BRANCH))
              && (rs2 == reg_dest);
    hazard  = out_valid && (mem_access == 2'b01) && (reg_dest != 5'd0) && in_valid &&
              (haz_rs1 || haz_rs2);
    stall    = (bub_cnt != 2'd0) || hazard;
    in_ready = !stall && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (reset || flush)            bub_cnt <= 2'd0;
    else if (hazard && out_ready)  bub_cnt <= 2'(LU_BUBBLES);
    else if (bub_cnt != 2'd0)      bub_cnt <= bub_cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid        <= 1'b0;
      immediate        <= '0;
      reg1_out         <= '0;
      reg2_out         <= '0;
      reg_dest         <= '0;
      pc_out           <= '0;
      funct3           <= '0;
      funct7           <= '0;
      writeback_enable <= 1'b0;
      writeback_source <= '0;
      mem_access       <= '0;
      jump             <= 1'b0;
      branch           <= 1'b0;
      ALU_A_mux        <= 1'b0;
      ALU_B_mux        <= 1'b0;
      word_op          <= 1'b0;
      illegal          <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      immediate        <= dec.imm;
      reg1_out         <= rs1_val;
      reg2_out         <= rs2_val;
      reg_dest         <= rd;
      pc_out           <= pc_in;
      funct3           <= inst_data[14:12];
      funct7           <= inst_data[31:25];
      writeback_enable <= dec.wb;
      writeback_source <= dec.src;
      mem_access       <= dec.mem;
      jump             <= dec.jump;
      branch           <= dec.branch;
      ALU_A_mux        <= dec.a_sel;
      ALU_B_mux        <= dec.b_sel;
      word_op          <= dec.word;
      illegal          <= dec.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rvz_decode_stage.sv
// Directed bench for rvz_decode_stage: a 64-bit/32-reg instance plus a 32-bit/16-reg
// instance sharing the same stimulus.
module tb_rvz_decode_stage;
  logic        clk = 1'b0;
  logic        reset, in_valid, flush, reg_wenable, out_ready;
  logic [31:0] inst_data, pc_in;
  logic [4:0]  reg_waddr;
  logic [63:0] reg_wdata;

  logic        in_ready, out_valid, wb, jump, branch, a_mux, b_mux, word_op, illegal;
  logic [63:0] immediate, reg1, reg2;
  logic [4:0]  reg_dest;
  logic [31:0] pc_out;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [1:0]  wb_src, mem_access;

  logic        s_in_ready, s_out_valid, s_wb, s_jump, s_branch, s_a, s_b, s_word, s_illegal;
  logic [31:0] s_imm, s_reg1, s_reg2, s_pc;
  logic [4:0]  s_dest;
  logic [2:0]  s_f3;
  logic [6:0]  s_f7;
  logic [1:0]  s_src, s_mem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rvz_decode_stage #(.XLEN(64), .PC_W(32), .NREGS(32), .LU_BUBBLES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .inst_data(inst_data), .pc_in(pc_in), .flush(flush),
    .reg_wenable(reg_wenable), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .immediate(immediate),
    .reg1_out(reg1), .reg2_out(reg2), .reg_dest(reg_dest), .pc_out(pc_out),
    .funct3(funct3), .funct7(funct7), .writeback_enable(wb), .writeback_source(wb_src),
    .mem_access(mem_access), .jump(jump), .branch(branch), .ALU_A_mux(a_mux),
    .ALU_B_mux(b_mux), .word_op(word_op), .illegal(illegal));

  rvz_decode_stage #(.XLEN(32), .PC_W(32), .NREGS(16), .LU_BUBBLES(0)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .inst_data(inst_data), .pc_in(pc_in), .flush(flush),
    .reg_wenable(reg_wenable), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata[31:0]),
    .out_valid(s_out_valid), .out_ready(out_ready), .immediate(s_imm),
    .reg1_out(s_reg1), .reg2_out(s_reg2), .reg_dest(s_dest), .pc_out(s_pc),
    .funct3(s_f3), .funct7(s_f7), .writeback_enable(s_wb), .writeback_source(s_src),
    .mem_access(s_mem), .jump(s_jump), .branch(s_branch), .ALU_A_mux(s_a),
    .ALU_B_mux(s_b), .word_op(s_word), .illegal(s_illegal));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; inst_data = inst; pc_in = pc;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; reg_wenable = 1'b0; out_ready = 1'b0;
    inst_data = '0; pc_in = '0; reg_waddr = '0; reg_wdata = '0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", immediate, 64'd0);
    chk("rst_wb", 64'(wb), 64'd0);
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // ADDI x5,x0,-1
    out_ready = 1'b1;
    present(32'hFFF00293, 32'h100);
    #1 chk("addi_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", immediate, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_wb", 64'(wb), 64'd1);
    chk("addi_bmux", 64'(b_mux), 64'd1);
    chk("addi_dest", 64'(reg_dest), 64'd5);
    chk("addi_pc", 64'(pc_out), 64'h100);
    in_valid = 1'b0;
    tick();
    chk("consume_drop", 64'(out_valid), 64'd0);

    // Same-cycle write bypass, then x0 write ignored
    present(32'h00738433, 32'h104);
    reg_wenable = 1'b1; reg_waddr = 5'd7; reg_wdata = 64'h1234;
    tick();
    chk("byp_reg1", reg1, 64'h1234);
    chk("byp_reg2", reg2, 64'h1234);
    chk("add_bmux", 64'(b_mux), 64'd0);
    present(32'h007004B3, 32'h108);
    reg_waddr = 5'd0; reg_wdata = 64'd5;
    tick();
    chk("x0_reads_0", reg1, 64'd0);
    chk("x7_stored", reg2, 64'h1234);
    reg_wenable = 1'b0;

    // LD x3,0(x1) followed by ADD x4,x3,x2
    present(32'h0000B183, 32'h10C);
    tick();
    chk("ld_mem", 64'(mem_access), 64'd1);
    chk("ld_src", 64'(wb_src), 64'd1);
    present(32'h00218233, 32'h110);
    #1 chk("lu_ready_c0", 64'(in_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    chk("lu_ready_c1", 64'(in_ready), 64'd0);
    tick();
    chk("lu_ready_c2", 64'(in_ready), 64'd1);
    tick();
    chk("lu_add_valid", 64'(out_valid), 64'd1);
    chk("lu_add_dest", 64'(reg_dest), 64'd4);

    // BEQ imm -4096, JAL 0, SD x2,-8(x1), LUI x1,0x80000
    present(32'h80000063, 32'h114);
    tick();
    chk("beq_branch", 64'(branch), 64'd1);
    chk("beq_imm", immediate, 64'hFFFF_FFFF_FFFF_F000);
    chk("beq_wb", 64'(wb), 64'd0);
    present(32'h0000006F, 32'h118);
    tick();
    chk("jal_jump", 64'(jump), 64'd1);
    chk("jal_src", 64'(wb_src), 64'd3);
    chk("jal_imm", immediate, 64'd0);
    chk("jal_amux", 64'(a_mux), 64'd1);
    chk("jal_rd0_wb", 64'(wb), 64'd0);
    present(32'hFE20BC23, 32'h11C);
    tick();
    chk("sd_imm", immediate, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("sd_mem", 64'(mem_access), 64'd2);
    present(32'h800000B7, 32'h120);
    tick();
    chk("lui_imm", immediate, 64'hFFFF_FFFF_8000_0000);
    chk("lui_src", 64'(wb_src), 64'd2);

    // Backpressure hold, then flush
    present(32'h00700313, 32'h124);
    tick();
    out_ready = 1'b0;
    present(32'h00100513, 32'h128);
    #1 chk("hold_ready_c0", 64'(in_ready), 64'd0);
    tick();
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_dest", 64'(reg_dest), 64'd6);
    chk("hold_imm", immediate, 64'd7);
    flush = 1'b1;
    #1 chk("flush_ready", 64'(in_ready), 64'd0);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    // Flush beats a same-cycle accept; regfile write still lands
    reg_wenable = 1'b1; reg_waddr = 5'd11; reg_wdata = 64'hABC;
    #1 chk("flush_acc_ready", 64'(in_ready), 64'd1);
    tick();
    chk("flush_discard", 64'(out_valid), 64'd0);
    flush = 1'b0; reg_wenable = 1'b0; out_ready = 1'b1;
    present(32'h00058633, 32'h12C);
    tick();
    chk("flush_wr_valid", 64'(out_valid), 64'd1);
    chk("flush_wr_reg1", reg1, 64'hABC);

    // OP-IMM-32 and out-of-range rd on both builds
    present(32'h0010029B, 32'h130);
    tick();
    chk("w_word", 64'(word_op), 64'd1);
    chk("w_illegal64", 64'(illegal), 64'd0);
    chk("w_valid32", 64'(s_out_valid), 64'd1);
    chk("w_illegal32", 64'(s_illegal), 64'd1);
    chk("w_wb32", 64'(s_wb), 64'd0);
    present(32'h00100A13, 32'h134);
    tick();
    chk("rd20_illegal16", 64'(s_illegal), 64'd1);
    chk("rd20_illegal32", 64'(illegal), 64'd0);
    chk("rd20_dest", 64'(reg_dest), 64'd20);

    // Reset mid-operation drops held instruction and clears registers
    out_ready = 1'b0;
    present(32'h00100513, 32'h138);
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    reset = 1'b0; out_ready = 1'b1;
    present(32'h00738433, 32'h13C);
    tick();
    chk("midrst_x7", reg1, 64'd0);
    in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
